// File: rtl/pkt_checker_rx.sv
// -----------------------------------------------------------------------------
// pkt_checker_rx
//
// Receive-side traffic checker for router bring-up. It consumes packets from one
// AXI-Stream egress port and checks each one:
//   flit 0                 must equal exp_hdr                  (error 1, then drain)
//   flit 1                 unchecked
//   flits 2 .. exp_len-3   low byte must equal idx-1            (error 2)
//   flit exp_len-2         unchecked
//   flit exp_len-1         needs tlast (error 3, then drain) and TAIL_WORD (error 4)
//   tlast before exp_len-1 ends the packet with error 3
//   tkeep == 0 on any checked flit                             (error 5, lowest priority)
// When one flit breaks several rules, the lowest error code is reported.
// Only the first error of a packet updates err_code/err_flag. The packet is
// counted once, good or bad, on its tlast handshake.
// Latency runs from the tx_start pulse to the tlast handshake.
//
// Optional build macro: CHECKER_BACKPRESSURE_EN
//   defined   : s_tready is additionally gated by a 4-bit LFSR (x^4+x^3+1,
//               seed 4'b1001) that advances every cycle outside reset.
//   undefined : s_tready is simply enable delayed by one cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   enable          accept traffic when 1 (reflected on s_tready one cycle later)
//   exp_hdr         required flit-0 data
//   exp_len         flits per packet (4..255)
//   tx_start        launch pulse from the traffic generator, starts the timer
//   s_t*            AXI-Stream slave
//   pkt_done        one-cycle pulse per completed packet
//   pkt_count       good packets (saturating)
//   err_count       bad packets (saturating)
//   err_code        code of the most recent packet error
//   err_flag        sticky error indicator
//   last_latency    latency of the most recent packet (0 if the timer was idle)
//   max_latency     largest latency seen
// -----------------------------------------------------------------------------
module pkt_checker_rx #(
    parameter int                DATA_W    = 64,
    parameter int                KEEP_W    = 8,
    parameter logic [DATA_W-1:0] TAIL_WORD = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [63:0]       exp_hdr,
    input  logic [7:0]        exp_len,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic              pkt_done,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count,
    output logic [2:0]        err_code,
    output logic              err_flag,
    output logic [15:0]       last_latency,
    output logic [15:0]       max_latency
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_TAIL,
        ST_DRAIN
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_HDR  = 3'd1;
    localparam logic [2:0] ERR_SEQ  = 3'd2;
    localparam logic [2:0] ERR_LAST = 3'd3;
    localparam logic [2:0] ERR_TAIL = 3'd4;
    localparam logic [2:0] ERR_KEEP = 3'd5;

    state_t      state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic        pkt_err_reg, pkt_err_next;   // current packet already has an error
    logic        enable_q_reg;
    logic        pkt_done_reg;
    logic [15:0] pkt_count_reg, err_count_reg;
    logic [2:0]  err_code_reg;
    logic        err_flag_reg;
    logic [15:0] last_latency_reg, max_latency_reg;
    logic [15:0] timer_reg;
    logic        timer_run_reg;

    logic        hs;
    logic        checking;
    logic [2:0]  flit_err;
    logic        pkt_end;
    logic        pkt_bad;
    logic        new_err;
    logic [7:0]  last_idx;
    logic [7:0]  body_last;
    logic [15:0] lat_sample;

    assign hs        = s_tvalid & s_tready;
    assign checking  = (state_reg != ST_DRAIN);
    assign last_idx  = exp_len - 8'd1;
    assign body_last = exp_len - 8'd3;

    // -------------------------------------------------------------------------
    // Next state and per-flit error classification
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        pkt_err_next = pkt_err_reg;
        flit_err     = ERR_NONE;
        pkt_end      = 1'b0;

        if (hs) begin
            idx_next = idx_reg + 8'd1;

            case (state_reg)
                ST_IDLE: begin
                    if (s_tdata != exp_hdr) begin
                        flit_err   = ERR_HDR;
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_HDR;
                    end
                end
                ST_HDR: begin
                    state_next = (exp_len == 8'd4) ? ST_TAIL : ST_BODY;
                end
                ST_BODY: begin
                    if (s_tdata[7:0] != (idx_reg - 8'd1)) begin
                        flit_err = ERR_SEQ;
                    end
                    if (idx_reg == body_last) begin
                        state_next = ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (idx_reg == last_idx) begin
                        if (!s_tlast) begin
                            // Packet overran its length: discard until tlast.
                            flit_err   = ERR_LAST;
                            state_next = ST_DRAIN;
                        end else if (s_tdata != TAIL_WORD) begin
                            flit_err = ERR_TAIL;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_next = ST_DRAIN;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // tlast always closes the packet, whatever state we are in.
            if (s_tlast) begin
                if (checking && (flit_err == ERR_NONE) && (idx_reg != last_idx)) begin
                    flit_err = ERR_LAST;
                end
                pkt_end    = 1'b1;
                state_next = ST_IDLE;
                idx_next   = 8'd0;
            end

            // Keep check only reports when nothing more specific fired.
            if (checking && (flit_err == ERR_NONE) && (s_tkeep == '0)) begin
                flit_err = ERR_KEEP;
            end

            pkt_err_next = pkt_end ? 1'b0 : (pkt_err_reg | (flit_err != ERR_NONE));
        end
    end

    assign pkt_bad    = pkt_err_reg | (flit_err != ERR_NONE);
    assign new_err    = hs & (flit_err != ERR_NONE) & ~pkt_err_reg;
    assign lat_sample = (timer_reg == 16'hFFFF) ? 16'hFFFF : (timer_reg + 16'd1);

    // -------------------------------------------------------------------------
    // Ready generation
    // -------------------------------------------------------------------------
`ifdef CHECKER_BACKPRESSURE_EN
    logic [3:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 4'b1001;
        end else begin
            lfsr_reg <= {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
        end
    end

    assign s_tready = enable_q_reg & lfsr_reg[0];
`else
    assign s_tready = enable_q_reg;
`endif

    // -------------------------------------------------------------------------
    // State, statistics and latency registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= 8'd0;
            pkt_err_reg      <= 1'b0;
            enable_q_reg     <= 1'b0;
            pkt_done_reg     <= 1'b0;
            pkt_count_reg    <= 16'd0;
            err_count_reg    <= 16'd0;
            err_code_reg     <= 3'd0;
            err_flag_reg     <= 1'b0;
            last_latency_reg <= 16'd0;
            max_latency_reg  <= 16'd0;
            timer_reg        <= 16'd0;
            timer_run_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            pkt_err_reg  <= pkt_err_next;
            enable_q_reg <= enable;
            pkt_done_reg <= pkt_end;

            if (new_err) begin
                err_code_reg <= flit_err;
                err_flag_reg <= 1'b1;
            end

            if (pkt_end) begin
                if (pkt_bad) begin
                    if (err_count_reg != 16'hFFFF) begin
                        err_count_reg <= err_count_reg + 16'd1;
                    end
                end else begin
                    if (pkt_count_reg != 16'hFFFF) begin
                        pkt_count_reg <= pkt_count_reg + 16'd1;
                    end
                end

                if (timer_run_reg) begin
                    last_latency_reg <= lat_sample;
                    if (lat_sample > max_latency_reg) begin
                        max_latency_reg <= lat_sample;
                    end
                end else begin
                    last_latency_reg <= 16'd0;
                end
            end

            // tx_start wins over stop, so a launch coinciding with tlast
            // restarts the timer after the old value has been sampled.
            if (tx_start) begin
                timer_reg     <= 16'd0;
                timer_run_reg <= 1'b1;
            end else if (pkt_end) begin
                timer_run_reg <= 1'b0;
            end else if (timer_run_reg && (timer_reg != 16'hFFFF)) begin
                timer_reg <= timer_reg + 16'd1;
            end
        end
    end

    assign pkt_done     = pkt_done_reg;
    assign pkt_count    = pkt_count_reg;
    assign err_count    = err_count_reg;
    assign err_code     = err_code_reg;
    assign err_flag     = err_flag_reg;
    assign last_latency = last_latency_reg;
    assign max_latency  = max_latency_reg;

endmodule
